// File: rtl/lisnoc_wormhole_arbiter.sv
// -----------------------------------------------------------------------------
// lisnoc_wormhole_arbiter
//
// Round-robin wormhole arbiter for one router output port and one virtual
// channel. A packet (HEADER .. LAST) keeps the port locked to its input until
// the LAST flit has moved. A SINGLE flit is arbitrated and forwarded without
// locking. Flits move at up to one per cycle and pass through with zero
// latency.
//
// Ports:
//   clk            : clock; all state changes on its rising edge
//   rst            : synchronous reset, active high
//   switch_request : [PORTS] input p holds a flit for this output
//   switch_flit    : [PORTS*FLIT_WIDTH] flit of input p in slice p
//   switch_read    : [PORTS] one-hot or zero, pops the selected input's flit
//   out_flit       : [FLIT_WIDTH] flit presented to the output FIFO
//   out_valid      : out_flit is valid
//   out_ready      : output FIFO accepts a flit this cycle
//   grant          : [PORTS] registered one-hot owner while locked, else 0
//   busy           : registered, high while a packet holds the port
//   err_proto      : registered one-cycle pulse on a framing error
//
// Handshake: a flit moves in a cycle where out_valid and out_ready are both
// high. out_valid never depends on out_ready; switch_read is the one-hot of
// the selected input gated by that transfer, so the input stage pops exactly
// the flit the output FIFO accepted.
// -----------------------------------------------------------------------------
module lisnoc_wormhole_arbiter #(
   parameter  int PORTS           = 5,
   parameter  int FLIT_DATA_WIDTH = 32,
   parameter  int FLIT_TYPE_WIDTH = 2,
   localparam int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [PORTS-1:0]            switch_request,
   input  logic [PORTS*FLIT_WIDTH-1:0] switch_flit,
   output logic [PORTS-1:0]            switch_read,
   output logic [FLIT_WIDTH-1:0]       out_flit,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [PORTS-1:0]            grant,
   output logic                        busy,
   output logic                        err_proto
);

   localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

   localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_PAYLOAD = FLIT_TYPE_WIDTH'(0);
   localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_HEADER  = FLIT_TYPE_WIDTH'(1);
   localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_LAST    = FLIT_TYPE_WIDTH'(2);
   localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_SINGLE  = FLIT_TYPE_WIDTH'(3);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [PTR_W-1:0]           r_ptr;
   logic [PTR_W-1:0]           w_ptr_nxt;
   logic [PTR_W-1:0]           r_owner;
   logic [PTR_W-1:0]           w_owner_nxt;
   logic [PORTS-1:0]           r_grant;
   logic [PORTS-1:0]           w_grant_nxt;
   logic                       r_busy;
   logic                       r_err;
   logic                       w_err_nxt;

   logic [FLIT_WIDTH-1:0]      w_flits [PORTS];
   logic [PTR_W-1:0]           w_winner;
   logic                       w_any_req;
   logic [PTR_W-1:0]           w_sel;
   logic                       w_transfer;
   logic [FLIT_TYPE_WIDTH-1:0] w_type;

   // Unpack the flat flit bus into one entry per input.
   for (genvar g = 0; g < PORTS; g++) begin : g_unpack
      assign w_flits[g] = switch_flit[g*FLIT_WIDTH +: FLIT_WIDTH];
   end

   // Round-robin search: the lowest offset from ptr+1 that requests wins.
   // Scanning from the far end down lets the nearest hit overwrite the others.
   always_comb begin
      logic [PTR_W-1:0] v_idx;
      w_winner  = r_ptr;
      w_any_req = |switch_request;
      v_idx     = '0;
      for (int i = PORTS; i >= 1; i--) begin
         v_idx = PTR_W'((int'(r_ptr) + i) % PORTS);
         if (switch_request[v_idx]) begin
            w_winner = v_idx;
         end
      end
   end

   // Datapath: the arbitration winner in IDLE, the lock owner otherwise.
   assign w_sel    = (r_state == ST_IDLE) ? w_winner : r_owner;
   assign out_flit = w_flits[w_sel];
   assign w_type   = out_flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];

   // Forced low in reset so nothing is popped while the block is cleared.
   always_comb begin
      out_valid = 1'b0;
      if (!rst) begin
         if (r_state == ST_IDLE) begin
            out_valid = w_any_req;
         end else begin
            out_valid = switch_request[r_owner];
         end
      end
   end

   assign w_transfer = out_valid & out_ready;

   always_comb begin
      switch_read = '0;
      if (w_transfer) begin
         switch_read[w_sel] = 1'b1;
      end
   end

   // Next-state logic. A misplaced PAYLOAD/LAST in IDLE is forwarded as if it
   // were SINGLE; a HEADER/SINGLE inside a packet is forwarded without
   // dropping the lock. Both raise err_proto.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_err_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_transfer) begin
               w_ptr_nxt = w_winner;
               if (w_type == TYPE_HEADER) begin
                  w_state_nxt = ST_LOCKED;
                  w_owner_nxt = w_winner;
               end else if ((w_type == TYPE_PAYLOAD) || (w_type == TYPE_LAST)) begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         ST_LOCKED: begin
            if (w_transfer) begin
               if (w_type == TYPE_LAST) begin
                  w_state_nxt = ST_IDLE;
               end else if ((w_type == TYPE_HEADER) || (w_type == TYPE_SINGLE)) begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // grant/busy are registered copies of the next lock state, so they rise
   // the cycle after the HEADER and fall the cycle after the LAST.
   always_comb begin
      w_grant_nxt = '0;
      if (w_state_nxt == ST_LOCKED) begin
         w_grant_nxt[w_owner_nxt] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= PTR_W'(PORTS - 1);
         r_owner <= '0;
         r_grant <= '0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_grant <= w_grant_nxt;
         r_busy  <= (w_state_nxt == ST_LOCKED);
         r_err   <= w_err_nxt;
      end
   end

   assign grant     = r_grant;
   assign busy      = r_busy;
   assign err_proto = r_err;

endmodule
